alu_nibble_seq: RTL and testbench

Multi-cycle wide-operand front end for the 4-bit ALU slice. It accepts a W-bit operation over a valid/ready handshake and feeds one nibble per cycle, LSB first, into a single internal alu_4bit instance. It registers the carry between nibbles and assembles the result. It returns the W-bit result, carry-out and zero flag over a second valid/ready handshake, so one 4-bit datapath executes 8- to 32-bit operations.

---
 rtl/alu_seq_pkg.sv | 15 +
 rtl/alu_4bit.sv | 30 +++
 rtl/alu_nibble_seq.sv | 98 +++++++++
 tb/tb_alu_nibble_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared encodings for the nibble-serial ALU front end and its 4-bit slice.
package alu_seq_pkg;

  localparam logic [1:0] OP_NAND = 2'b00;
  localparam logic [1:0] OP_NOR  = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_4bit.sv
// 4-bit ALU slice: NAND, NOR, ADD, SUB (B inverted, caller supplies cin=1 for the LSB slice).
module alu_4bit
  import alu_seq_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic [1:0] s_op,
  output logic [3:0] z,
  output logic       cout
);

  logic [3:0] w_b;
  logic [4:0] w_sum;

  // The adder always runs so the carry chain is defined for every op.
  assign w_b   = (s_op == OP_SUB) ? ~b : b;
  assign w_sum = {1'b0, a} + {1'b0, w_b} + {4'b0000, cin};
  assign cout  = w_sum[4];

  always_comb begin
    z = w_sum[3:0];
    case (s_op)
      OP_NAND: z = ~(a & b);
      OP_NOR:  z = ~(a | b);
      default: z = w_sum[3:0];
    endcase
  end

endmodule

// File: rtl/alu_nibble_seq.sv
// Wide-operand sequencer: runs a W-bit op one nibble per cycle, LSB first, through
// a single alu_4bit, then holds the result behind a valid/ready handshake.
module alu_nibble_seq
  import alu_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_a,
  input  logic [4*NIBBLES-1:0]   in_b,
  input  logic [1:0]             in_op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_z,
  output logic                   out_cout,
  output logic                   out_zero
);

  localparam int               IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NIBBLES - 1);

  state_t                  r_state, w_next;
  logic [NIBBLES-1:0][3:0] r_a, r_b, r_res;
  logic [1:0]              r_op;
  logic                    r_carry;
  logic [IDX_W-1:0]        r_idx;

  logic [3:0] w_z;
  logic       w_cout;
  logic       w_last;

  assign w_last = (r_idx == LAST);

  alu_4bit u_alu (
    .a    (r_a[r_idx]),
    .b    (r_b[r_idx]),
    .cin  (r_carry),
    .s_op (r_op),
    .z    (w_z),
    .cout (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a     <= in_a;
          r_b     <= in_b;
          r_op    <= in_op;
          r_idx   <= '0;
          // SUB seeds carry-in of 1 to complete the two's complement of B.
          r_carry <= in_op[1] & in_op[0];
        end
        RUN: begin
          r_res[r_idx] <= w_z;
          r_carry      <= w_cout;
          if (!w_last) r_idx <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs are gated by DONE so nothing partial leaks out during RUN or reset.
  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    out_z     = out_valid ? r_res : '0;
    out_cout  = out_valid & r_op[1] & r_carry;
    out_zero  = out_valid & (r_res == '0);
  end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Scoreboard bench for alu_nibble_seq (NIBBLES=4): directed cases plus random ops.
module tb_alu_nibble_seq;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic [1:0]   in_op = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_z;
  logic         out_cout, out_zero;

  alu_nibble_seq #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_cout(out_cout), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] z;
    logic         c;
    logic         zr;
    int           acc;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain W-bit arithmetic on whole operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    exp_t e;
    logic [W:0] s;
    e.c = 1'b0;
    e.z = '0;
    case (op)
      2'b00: e.z = ~(a & b);
      2'b01: e.z = ~(a | b);
      2'b10: begin s = {1'b0, a} + {1'b0, b}; e.z = s[W-1:0]; e.c = s[W]; end
      default: begin e.z = a - b; e.c = (a >= b); end
    endcase
    e.zr  = (e.z == '0);
    e.acc = 0;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every DONE cycle must match the head; pop on handshake.
  logic prev_valid = 1'b0;
  logic chk_rdy = 1'b0;
  always @(negedge clk) begin
    if (chk_rdy) begin
      check("in_ready_after_handshake", {31'b0, in_ready}, 32'd1);
      chk_rdy <= 1'b0;
    end
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_output: got z=%h with empty scoreboard", out_z);
      end else begin
        if (!prev_valid)
          check("latency", cyc - sb_q[0].acc, N);
        check("result", {14'b0, out_cout, out_zero, out_z},
              {14'b0, sb_q[0].c, sb_q[0].zr, sb_q[0].z});
        check("in_ready_low_in_done", {31'b0, in_ready}, 32'd0);
        if (out_ready) begin
          void'(sb_q.pop_front());
          chk_rdy <= 1'b1;
        end
      end
    end
    prev_valid <= out_valid && !out_ready;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL %s_timeout: in_ready got 0 expected 1", name);
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    if (!out_valid) begin
      tests++; fails++;
      $display("FAIL %s_timeout: out_valid got 0 expected 1", name);
    end
  endtask

  // Drive a request, return right after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    exp_t e;
    wait_ready("issue");
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
    tick();
    e = model(a, b, op);
    e.acc = cyc;
    sb_q.push_back(e);
    in_valid = 1'b0; in_a = W'($urandom); in_b = W'($urandom); in_op = 2'($urandom);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op, input int hold);
    out_ready = (hold == 0);
    issue(a, b, op);
    if (hold > 0) begin
      wait_valid("hold");
      repeat (hold) tick();
      out_ready = 1'b1;
    end
    wait_ready("complete");
  endtask

  logic [W-1:0] da[7] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0005, 16'h1000, 16'hF0F0, 16'h00F0};
  logic [W-1:0] db[7] = '{16'h0FFF, 16'h0001, 16'h8000, 16'h0007, 16'h0001, 16'hFF00, 16'h000F};
  logic [1:0]   dop[7] = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b00, 2'b01};

  initial begin
    #2;
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check("reset_outputs", {29'b0, out_valid, out_cout, out_zero}, 32'd0);
    check("reset_out_z", {16'b0, out_z}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_op(da[i], db[i], dop[i], 0);

    // Backpressure in DONE with noisy inputs.
    out_ready = 1'b0;
    issue(16'h4321, 16'h1111, 2'b10);
    wait_valid("bp");
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid; in_a = W'($urandom); in_op = 2'($urandom);
      tick();
      check("bp_hold_valid", {30'b0, out_valid, in_ready}, 32'd2);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_ready("bp_release");
    repeat (3) tick();
    check("bp_single_handshake", sb_q.size(), 0);

    // Reset in the middle of RUN discards the op.
    issue(16'h1234, 16'h1111, 2'b10);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("midrun_reset_ready", {30'b0, in_ready, out_valid}, 32'd2);
    check("midrun_reset_z", {16'b0, out_z}, 32'd0);
    sb_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    run_op(16'h0001, 16'h0001, 2'b10, 0);

    for (int i = 0; i < 60; i++)
      run_op(W'($urandom), W'($urandom), 2'($urandom), int'($urandom_range(0, 3)));
    // Corner operands for carry/borrow chains.
    for (int i = 0; i < 8; i++)
      run_op((i[0] ? 16'hFFFF : 16'h0000), (i[1] ? 16'hFFFF : 16'h0001), {1'b1, i[2]}, 0);

    repeat (10) tick();
    check("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
